// File: rtl/push_led_ctrl.sv
// Push-button front end: per-channel synchronizer and debouncer, press pulse
// generation and a small LED display engine with follow / toggle / one-hot modes.
module push_led_ctrl #(
  parameter int N_CH      = 5,
  parameter int DB_CYCLES = 100000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sw,
  input  logic [1:0]      mode,
  output logic [N_CH-1:0] led,
  output logic [N_CH-1:0] press
);

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_FOLLOW  = 2'b00,
    MODE_TOGGLE  = 2'b01,
    MODE_ONEHOT  = 2'b10,
    MODE_FOLLOW2 = 2'b11
  } mode_t;

  logic [N_CH-1:0] r_sync1;
  logic [N_CH-1:0] r_sync2;
  logic [N_CH-1:0] r_db;
  logic [N_CH-1:0] r_dbPrev;
  logic [N_CH-1:0] r_latch;
  logic [CW-1:0]   r_cnt [N_CH];
  mode_t           r_mode;

  logic [N_CH-1:0] w_rise;
  logic [N_CH-1:0] w_lowest;
  logic [N_CH-1:0] w_latchNext;
  logic            w_modeChange;
  logic            w_showLatch;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sw;
      r_sync2 <= r_sync1;
    end
  end

  // The counter only ever reaches CNT_LAST while the mismatch persists, so the
  // flip edge also clears it and a short glitch can never wrap it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_cnt[i] <= '0;
          r_db[i]  <= ~r_db[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign w_rise       = r_db & ~r_dbPrev;
  assign w_lowest     = w_rise & (~w_rise + N_CH'(1));
  assign w_modeChange = (mode != r_mode);
  assign w_showLatch  = (r_mode == MODE_TOGGLE) || (r_mode == MODE_ONEHOT);

  // A mode change wipes the latch and swallows any press landing on that edge.
  always_comb begin
    w_latchNext = r_latch;
    if (w_modeChange) begin
      w_latchNext = '0;
    end else begin
      case (r_mode)
        MODE_TOGGLE: w_latchNext = r_latch ^ w_rise;
        MODE_ONEHOT: begin
          if (|w_rise) begin
            w_latchNext = w_lowest;
          end
        end
        default: w_latchNext = r_latch;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dbPrev <= '0;
      r_latch  <= '0;
      r_mode   <= MODE_FOLLOW;
      press    <= '0;
      led      <= '0;
    end else begin
      r_dbPrev <= r_db;
      r_latch  <= w_latchNext;
      r_mode   <= mode_t'(mode);
      press    <= w_rise;
      led      <= w_showLatch ? w_latchNext : r_db;
    end
  end

endmodule

// File: tb/tb_push_led_ctrl.sv
// Randomized scoreboard bench for push_led_ctrl: a window-based reference model
// predicts led/press per edge and a monitor compares them against the DUT.
module tb_push_led_ctrl;

  localparam int N  = 5;
  localparam int DB = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] sw;
  logic [1:0]   mode;
  logic [N-1:0] led;
  logic [N-1:0] press;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [2*N-1:0] expQ [$];

  logic [N-1:0] mS1, mS2, mDb, mDbPrev, mLatch;
  logic [1:0]   mMode;
  logic [N-1:0] hist [$];

  push_led_ctrl #(.N_CH(N), .DB_CYCLES(DB)) dut (
    .clk  (clk),
    .rst  (rst),
    .sw   (sw),
    .mode (mode),
    .led  (led),
    .press(press)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: a channel flips once its last DB synchronized samples all
  // disagree with its debounced level; synced sample = raw level two edges ago.
  task automatic applyStimulus(input logic r, input logic [N-1:0] s, input logic [1:0] m);
    logic [N-1:0] sample, newDb, rise, expLed, expPress;
    bit allDiff, found;
    rst  = r;
    sw   = s;
    mode = m;
    if (r) begin
      mS1 = '0; mS2 = '0; mDb = '0; mDbPrev = '0; mLatch = '0; mMode = 2'b00;
      hist.delete();
      expLed = '0;
      expPress = '0;
    end else begin
      sample = mS2;
      mS2 = mS1;
      mS1 = s;
      hist.push_back(sample);
      if (hist.size() > DB) void'(hist.pop_front());
      newDb = mDb;
      if (hist.size() == DB) begin
        for (int i = 0; i < N; i++) begin
          allDiff = 1'b1;
          foreach (hist[k]) if (hist[k][i] == mDb[i]) allDiff = 1'b0;
          if (allDiff) newDb[i] = ~mDb[i];
        end
      end
      rise = mDb & ~mDbPrev;
      if (m != mMode) begin
        mLatch = '0;
      end else if (mMode == 2'b01) begin
        for (int i = 0; i < N; i++) if (rise[i]) mLatch[i] = ~mLatch[i];
      end else if (mMode == 2'b10) begin
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (rise[i] && !found) begin
            mLatch = '0;
            mLatch[i] = 1'b1;
            found = 1'b1;
          end
        end
      end
      expLed   = (mMode == 2'b01 || mMode == 2'b10) ? mLatch : mDb;
      expPress = rise;
      mDbPrev = mDb;
      mDb     = newDb;
      mMode   = m;
    end
    expQ.push_back({expLed, expPress});
    @(negedge clk);
  endtask

  task automatic holdFor(input logic [N-1:0] s, input logic [1:0] m, input int n);
    repeat (n) applyStimulus(1'b0, s, m);
  endtask

  task automatic checkOutput(input logic [2*N-1:0] exp);
    nCompared++;
    if (led !== exp[2*N-1:N]) begin
      nMismatched++;
      if (nMismatched <= 40)
        $display("[TB] FAIL led @%0t: got %b expected %b", $time, led, exp[2*N-1:N]);
    end
    nCompared++;
    if (press !== exp[N-1:0]) begin
      nMismatched++;
      if (nMismatched <= 40)
        $display("[TB] FAIL press @%0t: got %b expected %b", $time, press, exp[N-1:0]);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() != 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    logic [N-1:0] rs;
    logic [1:0]   rm;
    int           len;

    applyStimulus(1'b1, '0, 2'b00);
    applyStimulus(1'b1, '0, 2'b00);
    holdFor('0, 2'b00, 4);

    // single held press in follow mode, then short glitch
    holdFor(5'b00001, 2'b00, 12);
    holdFor(5'b00000, 2'b00, 10);
    holdFor(5'b00100, 2'b00, 3);
    holdFor(5'b00000, 2'b00, 8);

    // toggle mode, three presses of channel 1
    holdFor(5'b00000, 2'b01, 4);
    repeat (3) begin
      holdFor(5'b00010, 2'b01, 10);
      holdFor(5'b00000, 2'b01, 10);
    end

    // one-hot, sequential then simultaneous presses
    holdFor(5'b00000, 2'b10, 4);
    holdFor(5'b01000, 2'b10, 10);
    holdFor(5'b00000, 2'b10, 10);
    holdFor(5'b10000, 2'b10, 10);
    holdFor(5'b00000, 2'b10, 10);
    holdFor(5'b01010, 2'b10, 10);
    holdFor(5'b00000, 2'b10, 10);

    // toggle to 00110 then switch mode while buttons stay held
    holdFor(5'b00000, 2'b01, 4);
    holdFor(5'b00110, 2'b01, 10);
    holdFor(5'b00110, 2'b10, 10);
    holdFor(5'b00000, 2'b10, 10);

    // reset in the middle of a debounce window
    holdFor(5'b00000, 2'b00, 6);
    holdFor(5'b00001, 2'b00, 2);
    applyStimulus(1'b1, 5'b00001, 2'b00);
    holdFor(5'b00001, 2'b00, 12);
    holdFor(5'b00000, 2'b00, 10);

    // randomized segments mixing glitches, long holds, mode changes and resets
    rm = 2'b00;
    for (int seg = 0; seg < 400; seg++) begin
      rs  = N'($urandom);
      len = $urandom_range(1, 9);
      if ($urandom_range(0, 5) == 0) rm = 2'($urandom);
      if ($urandom_range(0, 39) == 0) applyStimulus(1'b1, rs, rm);
      holdFor(rs, rm, len);
    end
    holdFor('0, rm, 10);

    @(posedge clk);
    #2;
    nCompared++;
    if (expQ.size() != 0) begin
      nMismatched++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
